// File: rtl/hdmi_axi_addr_gen.sv
// hdmi_axi_addr_gen: walks a frame buffer line by line, issuing fixed-length
// AXI read bursts through a kick/busy handshake, throttled by pixel FIFO fill.
module hdmi_axi_addr_gen #(
   parameter int X_SIZE          = 256,
   parameter int Y_SIZE          = 256,
   parameter int BYTES_PER_PIXEL = 4,
   parameter int BURST_WORDS     = 256,
   parameter int FIFO_THRESHOLD  = 6400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        prefetch_frame,
   input  logic [31:0] base_addr,
   input  logic [31:0] line_stride,
   input  logic [31:0] fifo_level,
   input  logic        busy,
   output logic        kick,
   output logic [31:0] read_addr,
   output logic [31:0] read_num,
   output logic        active,
   output logic        frame_done,
   output logic        overrun
);
   localparam int BPL = X_SIZE / BURST_WORDS;
   localparam int CW = BPL > 1 ? $clog2(BPL) : 1;
   localparam int LW = Y_SIZE > 1 ? $clog2(Y_SIZE) : 1;
   localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * BYTES_PER_PIXEL);
   localparam logic [31:0] PACKED = 32'(X_SIZE * BYTES_PER_PIXEL);
   localparam logic [31:0] THRESH = 32'(FIFO_THRESHOLD);
   localparam logic [CW-1:0] COL_LAST = CW'(BPL - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(Y_SIZE - 1);

   typedef enum logic [1:0] {IDLE, ROOM, ISSUE, ACK} state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   line_base_q, line_base_d;
   logic [31:0]   stride_q, stride_d;
   logic [CW-1:0] col_q, col_d;
   logic [LW-1:0] line_q, line_d;
   logic          active_q, active_d;
   logic          done_q, done_d;
   logic          overrun_q, overrun_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         line_base_q <= '0;
         stride_q    <= '0;
         col_q       <= '0;
         line_q      <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         line_base_q <= line_base_d;
         stride_q    <= stride_d;
         col_q       <= col_d;
         line_q      <= line_d;
         active_q    <= active_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      line_base_d = line_base_q;
      stride_d    = stride_q;
      col_d       = col_q;
      line_d      = line_q;
      active_d    = active_q;
      done_d      = 1'b0;
      // a request outside IDLE (including on the final acceptance) is dropped
      overrun_d   = overrun_q | (prefetch_frame && state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (prefetch_frame) begin
               state_d     = ROOM;
               addr_d      = base_addr;
               line_base_d = base_addr;
               stride_d    = line_stride == '0 ? PACKED : line_stride;
               col_d       = '0;
               line_d      = '0;
               active_d    = 1'b1;
            end
         end
         ROOM:  state_d = (fifo_level < THRESH && !busy) ? ISSUE : ROOM;
         ISSUE: state_d = ACK;
         ACK: begin
            if (busy) begin
               if (col_q == COL_LAST && line_q == LINE_LAST) begin
                  state_d  = IDLE;
                  done_d   = 1'b1;
                  active_d = 1'b0;
               end else if (col_q != COL_LAST) begin
                  state_d = ROOM;
                  col_d   = col_q + CW'(1);
                  addr_d  = addr_q + BURST_BYTES;
               end else begin
                  state_d     = ROOM;
                  col_d       = '0;
                  line_d      = line_q + LW'(1);
                  line_base_d = line_base_q + stride_q;
                  addr_d      = line_base_q + stride_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign kick       = state_q == ISSUE || state_q == ACK;
   assign read_addr  = addr_q;
   assign read_num   = 32'(BURST_WORDS);
   assign active     = active_q;
   assign frame_done = done_q;
   assign overrun    = overrun_q;
endmodule

// File: tb/tb_hdmi_axi_addr_gen.sv
// tb_hdmi_axi_addr_gen: directed bench over three geometries (default 256x256,
// 512x4 with explicit stride, single-burst frame at a wrapping address).
module tb_hdmi_axi_addr_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  pf = '0;
   logic [2:0]  bz = '0;
   logic [31:0] base = '0;
   logic [31:0] stride = '0;
   logic [31:0] fifo = '0;
   logic [2:0]  kk, act, dn, ov;
   logic [31:0] ra [3];
   logic [31:0] rn [3];
   int          checks = 0;
   int          errors = 0;
   int          dcnt0 = 0;

   always #5 clk = ~clk;

   hdmi_axi_addr_gen u0 (
      .clk(clk), .rst(rst), .prefetch_frame(pf[0]), .base_addr(base),
      .line_stride(stride), .fifo_level(fifo), .busy(bz[0]), .kick(kk[0]),
      .read_addr(ra[0]), .read_num(rn[0]), .active(act[0]),
      .frame_done(dn[0]), .overrun(ov[0]));

   hdmi_axi_addr_gen #(.X_SIZE(512), .Y_SIZE(4)) u1 (
      .clk(clk), .rst(rst), .prefetch_frame(pf[1]), .base_addr(base),
      .line_stride(stride), .fifo_level(fifo), .busy(bz[1]), .kick(kk[1]),
      .read_addr(ra[1]), .read_num(rn[1]), .active(act[1]),
      .frame_done(dn[1]), .overrun(ov[1]));

   hdmi_axi_addr_gen #(.X_SIZE(256), .Y_SIZE(1)) u2 (
      .clk(clk), .rst(rst), .prefetch_frame(pf[2]), .base_addr(base),
      .line_stride(stride), .fifo_level(fifo), .busy(bz[2]), .kick(kk[2]),
      .read_addr(ra[2]), .read_num(rn[2]), .active(act[2]),
      .frame_done(dn[2]), .overrun(ov[2]));

   always @(posedge clk) if (dn[0]) dcnt0 <= dcnt0 + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pf = '0; bz = '0; fifo = '0;
      step();
      rst = 1'b0;
   endtask

   // waits for kick, checks the address on every kick-high cycle, and raises
   // busy on the (d+1)-th such cycle; h returns how many cycles kick stayed high
   task automatic serve(input int i, input logic [31:0] ea, input int d, output int h);
      int n = 0;
      h = 0;
      while (!kk[i] && n < 20) begin step(); n++; end
      checks++;
      if (!kk[i]) begin
         errors++;
         $display("FAIL kick_wait inst%0d: kick=%b, required 1 within 20 cycles", i, kk[i]);
         return;
      end
      while (kk[i] && h < 50) begin
         checks++;
         if (ra[i] !== ea) begin
            errors++;
            $display("FAIL read_addr inst%0d: got %h, required %h", i, ra[i], ea);
         end
         h++;
         if (h == d + 1) bz[i] = 1'b1;
         step();
      end
      bz[i] = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      step();
      checks++;
      if ({kk[0], act[0], dn[0], ov[0]} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: kick/active/done/overrun=%b, required 0000", {kk[0], act[0], dn[0], ov[0]});
      end
      checks++;
      if (ra[0] !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, required 0", ra[0]); end
      checks++;
      if (rn[0] !== 32'd256 || rn[1] !== 32'd256 || rn[2] !== 32'd256) begin
         errors++;
         $display("FAIL read_num: got %0d/%0d/%0d, required 256", rn[0], rn[1], rn[2]);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_frame();
      int h;
      int d0;
      do_reset();
      base = 32'h1000_0000; stride = '0; fifo = '0;
      pf[0] = 1'b1;
      step();
      pf[0] = 1'b0;
      checks++;
      if (act[0] !== 1'b1 || kk[0] !== 1'b0) begin
         errors++;
         $display("FAIL start: active=%b kick=%b, required 1 0", act[0], kk[0]);
      end
      step();
      checks++;
      if (kk[0] !== 1'b1) begin errors++; $display("FAIL first_kick_latency: kick=%b, required 1", kk[0]); end
      d0 = dcnt0;
      for (int n = 0; n < 256; n++) serve(0, 32'h1000_0000 + 32'(n) * 32'h400, 1, h);
      checks++;
      if (dn[0] !== 1'b1 || act[0] !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: done=%b active=%b, required 1 0", dn[0], act[0]);
      end
      checks++;
      if (ra[0] !== 32'h1003_FC00) begin errors++; $display("FAIL hold_addr: got %h, required 1003fc00", ra[0]); end
      step();
      step();
      checks++;
      if (dn[0] !== 1'b0 || dcnt0 !== d0 + 1) begin
         errors++;
         $display("FAIL done_pulse: done=%b pulses=%0d, required 0 and 1", dn[0], dcnt0 - d0);
      end
   endtask

   task automatic test_stride();
      int h;
      logic [31:0] exp1 [8] = '{32'h0, 32'h400, 32'h1000, 32'h1400, 32'h2000, 32'h2400, 32'h3000, 32'h3400};
      do_reset();
      base = '0; stride = 32'h1000;
      pf[1] = 1'b1;
      step();
      pf[1] = 1'b0;
      for (int n = 0; n < 8; n++) serve(1, exp1[n], 1, h);
      checks++;
      if (dn[1] !== 1'b1 || act[1] !== 1'b0) begin
         errors++;
         $display("FAIL stride_done: done=%b active=%b, required 1 0", dn[1], act[1]);
      end
      stride = '0;
   endtask

   task automatic test_fifo_throttle();
      int h;
      do_reset();
      base = 32'h1000_0000;
      pf[0] = 1'b1;
      step();
      pf[0] = 1'b0;
      serve(0, 32'h1000_0000, 1, h);
      fifo = 32'd6400;
      for (int n = 0; n < 10; n++) begin
         step();
         checks++;
         if (kk[0] !== 1'b0 || act[0] !== 1'b1) begin
            errors++;
            $display("FAIL fifo_block: kick=%b active=%b, required 0 1", kk[0], act[0]);
         end
      end
      fifo = 32'd6399;
      step();
      checks++;
      if (kk[0] !== 1'b1 || ra[0] !== 32'h1000_0400) begin
         errors++;
         $display("FAIL fifo_release: kick=%b addr=%h, required 1 10000400", kk[0], ra[0]);
      end
      fifo = '0;
   endtask

   task automatic test_busy();
      int h;
      do_reset();
      base = 32'h1000_0000;
      bz[0] = 1'b1;
      pf[0] = 1'b1;
      step();
      pf[0] = 1'b0;
      for (int n = 0; n < 8; n++) begin
         step();
         checks++;
         if (kk[0] !== 1'b0) begin errors++; $display("FAIL busy_block: kick=%b, required 0", kk[0]); end
      end
      bz[0] = 1'b0;
      step();
      checks++;
      if (kk[0] !== 1'b1) begin errors++; $display("FAIL busy_release: kick=%b, required 1", kk[0]); end
      serve(0, 32'h1000_0000, 5, h);
      checks++;
      if (h !== 6) begin errors++; $display("FAIL kick_hold: high %0d cycles, required 6", h); end
      serve(0, 32'h1000_0400, 1, h);
      checks++;
      if (h !== 2) begin errors++; $display("FAIL kick_min: high %0d cycles, required 2", h); end
   endtask

   task automatic test_overrun();
      int h;
      do_reset();
      base = 32'h1000_0000;
      pf[0] = 1'b1;
      step();
      pf[0] = 1'b0;
      serve(0, 32'h1000_0000, 1, h);
      serve(0, 32'h1000_0400, 1, h);
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, required 0", ov[0]); end
      base = 32'h2000_0000;
      pf[0] = 1'b1;
      step();
      pf[0] = 1'b0;
      checks++;
      if (ov[0] !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, required 1", ov[0]); end
      serve(0, 32'h1000_0800, 1, h);
      checks++;
      if (ov[0] !== 1'b1 || act[0] !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: overrun=%b active=%b, required 1 1", ov[0], act[0]);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({kk[0], act[0], dn[0], ov[0]} !== 4'b0000 || ra[0] !== 32'h0) begin
         errors++;
         $display("FAIL midframe_reset: flags=%b addr=%h, required 0000 0", {kk[0], act[0], dn[0], ov[0]}, ra[0]);
      end
      pf[0] = 1'b1;
      step();
      pf[0] = 1'b0;
      serve(0, 32'h2000_0000, 1, h);
   endtask

   task automatic test_wrap();
      int h;
      do_reset();
      base = 32'hFFFF_FC00;
      pf[2] = 1'b1;
      step();
      pf[2] = 1'b0;
      serve(2, 32'hFFFF_FC00, 1, h);
      checks++;
      if (dn[2] !== 1'b1 || act[2] !== 1'b0 || ra[2] !== 32'hFFFF_FC00) begin
         errors++;
         $display("FAIL wrap_done: done=%b active=%b addr=%h, required 1 0 fffffc00", dn[2], act[2], ra[2]);
      end
      step();
      checks++;
      if (dn[2] !== 1'b0) begin errors++; $display("FAIL wrap_pulse: done=%b, required 0", dn[2]); end
      base = 32'h0000_0800;
      pf[2] = 1'b1;
      step();
      pf[2] = 1'b0;
      serve(2, 32'h0000_0800, 1, h);
      checks++;
      if (dn[2] !== 1'b1) begin errors++; $display("FAIL second_frame_done: got %b, required 1", dn[2]); end
      base = 32'h0000_4000;
      pf[2] = 1'b1;
      step();
      pf[2] = 1'b0;
      step();
      checks++;
      if (kk[2] !== 1'b1 || ra[2] !== 32'h4000) begin
         errors++;
         $display("FAIL third_kick: kick=%b addr=%h, required 1 4000", kk[2], ra[2]);
      end
      bz[2] = 1'b1;
      step();
      pf[2] = 1'b1;
      step();
      pf[2] = 1'b0;
      bz[2] = 1'b0;
      checks++;
      if (dn[2] !== 1'b1 || ov[2] !== 1'b1 || act[2] !== 1'b0) begin
         errors++;
         $display("FAIL final_accept_overrun: done=%b overrun=%b active=%b, required 1 1 0", dn[2], ov[2], act[2]);
      end
      step();
      step();
      checks++;
      if (act[2] !== 1'b0 || kk[2] !== 1'b0) begin
         errors++;
         $display("FAIL ignored_start: active=%b kick=%b, required 0 0", act[2], kk[2]);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_stride();
      test_fifo_throttle();
      test_busy();
      test_overrun();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
